// File: rtl/axis_downsizer.sv
// AXI4-Stream width downsizer: splits each N_IN-byte beat into N_OUT-byte sub-words, skipping null ones.
// First sub-word 1 cycle after acceptance; a new beat is taken only with the last sub-word leaving, so m_tready stalls the slave side.
module axis_downsizer #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 1,
  parameter int U     = 1,
  parameter int R     = N_IN / N_OUT
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [8*N_IN-1:0]    s_tdata,
  input  logic [N_IN-1:0]      s_tkeep,
  input  logic                 s_tlast,
  input  logic [U-1:0]         s_tuser,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [8*N_OUT-1:0]   m_tdata,
  output logic [N_OUT-1:0]     m_tkeep,
  output logic                 m_tlast,
  output logic [U-1:0]         m_tuser
);

  localparam int SW = 8 * N_OUT;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  generate
    if ((N_IN % N_OUT) != 0 || R < 2 || (R * N_OUT) != N_IN) begin : g_bad_cfg
      $error("axis_downsizer: N_IN must be an integer multiple of N_OUT with N_IN/N_OUT >= 2");
    end
  endgenerate

  logic [0:0]          r_state;
  logic [R-1:0]        r_pend;
  logic [8*N_IN-1:0]   r_data;
  logic [N_IN-1:0]     r_keep;
  logic                r_last;
  logic [U-1:0]        r_user;
  logic                r_m_tvalid;
  logic [SW-1:0]       r_m_tdata;
  logic [N_OUT-1:0]    r_m_tkeep;
  logic                r_m_tlast;
  logic [U-1:0]        r_m_tuser;

  logic                w_accept;
  logic                w_xfer;
  logic                w_one_pend;
  logic [R-1:0]        w_in_mask;
  logic [R-1:0]        w_nmask;
  logic                w_nlast_only;
  logic [8*N_IN-1:0]   w_sdata;
  logic [N_IN-1:0]     w_skeep;
  logic                w_slast;
  logic [U-1:0]        w_suser;
  int                  w_idx;

  assign w_one_pend = (r_pend != '0) && ((r_pend & (r_pend - R'(1))) == '0);
  assign s_tready   = (r_state == IDLE) || (w_one_pend && m_tready);
  assign w_accept   = s_tvalid && s_tready;
  assign w_xfer     = r_m_tvalid && m_tready;

  // An all-null beat carrying tlast still has to deliver the end-of-packet marker on sub-word 0.
  always_comb begin
    w_in_mask = '0;
    for (int i = 0; i < R; i++) begin
      w_in_mask[i] = |s_tkeep[i*N_OUT +: N_OUT];
    end
    if (w_in_mask == '0 && s_tlast) begin
      w_in_mask[0] = 1'b1;
    end
  end

  always_comb begin
    w_nmask = r_pend;
    w_sdata = r_data;
    w_skeep = r_keep;
    w_slast = r_last;
    w_suser = r_user;
    if (w_accept) begin
      w_nmask = w_in_mask;
      w_sdata = s_tdata;
      w_skeep = s_tkeep;
      w_slast = s_tlast;
      w_suser = s_tuser;
    end else if (w_xfer) begin
      w_nmask = r_pend & (r_pend - R'(1));
    end
  end

  always_comb begin
    w_idx = 0;
    for (int i = R - 1; i >= 0; i--) begin
      if (w_nmask[i]) begin
        w_idx = i;
      end
    end
  end

  assign w_nlast_only = (w_nmask & (w_nmask - R'(1))) == '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_state    <= IDLE;
      r_pend     <= '0;
      r_data     <= '0;
      r_keep     <= '0;
      r_last     <= 1'b0;
      r_user     <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tkeep  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tuser  <= '0;
    end else if (w_accept || w_xfer) begin
      r_pend     <= w_nmask;
      r_state    <= (w_nmask != '0) ? BUSY : IDLE;
      r_m_tvalid <= (w_nmask != '0);
      if (w_accept) begin
        r_data <= s_tdata;
        r_keep <= s_tkeep;
        r_last <= s_tlast;
        r_user <= s_tuser;
      end
      if (w_nmask != '0) begin
        r_m_tdata <= w_sdata[w_idx*SW +: SW];
        r_m_tkeep <= w_skeep[w_idx*N_OUT +: N_OUT];
        r_m_tlast <= w_slast && w_nlast_only;
        r_m_tuser <= w_suser;
      end
    end
  end

  assign m_tvalid = r_m_tvalid;
  assign m_tdata  = r_m_tdata;
  assign m_tkeep  = r_m_tkeep;
  assign m_tlast  = r_m_tlast;
  assign m_tuser  = r_m_tuser;

endmodule
